// File: rtl/ep2_ctrl_pkg.sv
// Shared types for the ctrl demux selector scheduler.
// Scheduling modes and output-register states.
package ep2_ctrl_pkg;

  typedef enum logic {
    SCHED_RR     = 1'b0,
    SCHED_STATIC = 1'b1
  } sched_mode_e;

  typedef enum logic {
    SEL_EMPTY,
    SEL_FULL
  } sel_state_e;

endpackage

// File: rtl/ep2_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Doubled request vector scanned from the top so the lowest hit wins.
module ep2_rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl         = {req, req};
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 2*N-1; k >= 0; k--) begin
      if (dbl[k] && (k >= int'(ptr))) begin
        grant       = W'(k % N);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_dispatch_sched.sv
// Credit-based selector scheduler feeding the ctrl demux dispatcher.
// Credits are reserved at load time so candidates never see stale credit.
module ctrl_dispatch_sched
  import ep2_ctrl_pkg::*;
#(
  parameter int D_COUNT        = 2,
  parameter int SELECTOR_WIDTH = $clog2(D_COUNT),
  parameter int CREDIT_MAX     = 4,
  parameter int CNT_WIDTH      = $clog2(CREDIT_MAX+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_mode,
  input  logic [SELECTOR_WIDTH-1:0]     cfg_static_sel,
  input  logic [D_COUNT-1:0]            cfg_dest_en,
  output logic [SELECTOR_WIDTH-1:0]     m_sel_tdata,
  output logic                          m_sel_tvalid,
  input  logic                          m_sel_tready,
  input  logic [D_COUNT-1:0]            s_done,
  output logic [D_COUNT*CNT_WIDTH-1:0]  stat_credit,
  output logic [31:0]                   stat_grants,
  output logic                          err_credit_ovf
);

  localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(CREDIT_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [SELECTOR_WIDTH-1:0] LAST =
    SELECTOR_WIDTH'(D_COUNT-1);

  logic [CNT_WIDTH-1:0]      credit [D_COUNT];
  sel_state_e                state;
  sched_mode_e               mode;
  logic [SELECTOR_WIDTH-1:0] rr_ptr;
  logic [D_COUNT-1:0]        elig;
  logic [D_COUNT-1:0]        dec;
  logic [D_COUNT-1:0]        ovf;
  logic [SELECTOR_WIDTH-1:0] rr_idx;
  logic                      rr_vld;
  logic                      static_ok;
  logic [SELECTOR_WIDTH-1:0] cand_idx;
  logic                      cand_vld;
  logic                      hs;
  logic                      load;

  assign mode = sched_mode_e'(cfg_mode);
  assign hs   = m_sel_tvalid && m_sel_tready;

  always_comb begin
    elig = '0;
    for (int i = 0; i < D_COUNT; i++) begin
      elig[i] = cfg_dest_en[i] && (credit[i] != '0);
    end
  end

  ep2_rr_pick #(
    .N (D_COUNT),
    .W (SELECTOR_WIDTH)
  ) u_pick (
    .req         (elig),
    .ptr         (rr_ptr),
    .grant       (rr_idx),
    .grant_valid (rr_vld)
  );

  // Out-of-range static selections match no index and stay ineligible.
  always_comb begin
    static_ok = 1'b0;
    for (int i = 0; i < D_COUNT; i++) begin
      if (cfg_static_sel == SELECTOR_WIDTH'(i)) begin
        static_ok = elig[i];
      end
    end
  end

  always_comb begin
    cand_idx = rr_idx;
    cand_vld = rr_vld;
    if (mode == SCHED_STATIC) begin
      cand_idx = cfg_static_sel;
      cand_vld = static_ok;
    end
  end

  assign load = cand_vld && ((state == SEL_EMPTY) || hs);

  always_comb begin
    dec = '0;
    ovf = '0;
    for (int i = 0; i < D_COUNT; i++) begin
      dec[i] = load && (cand_idx == SELECTOR_WIDTH'(i));
      ovf[i] = s_done[i] && !dec[i] && (credit[i] == CMAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEL_EMPTY;
      m_sel_tvalid <= 1'b0;
      m_sel_tdata  <= '0;
      rr_ptr       <= '0;
    end else begin
      unique case (state)
        SEL_EMPTY: begin
          if (load) begin
            state        <= SEL_FULL;
            m_sel_tvalid <= 1'b1;
            m_sel_tdata  <= cand_idx;
          end
        end
        SEL_FULL: begin
          if (load) begin
            m_sel_tdata <= cand_idx;
          end else if (hs) begin
            state        <= SEL_EMPTY;
            m_sel_tvalid <= 1'b0;
          end
        end
        default: begin
          state        <= SEL_EMPTY;
          m_sel_tvalid <= 1'b0;
        end
      endcase
      if (load && (mode == SCHED_RR)) begin
        rr_ptr <= (cand_idx == LAST) ? '0 : cand_idx + 1'b1;
      end
    end
  end

  // A reservation and a return on the same destination cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < D_COUNT; i++) begin
      if (rst) begin
        credit[i] <= CMAX;
      end else if (dec[i] && !s_done[i]) begin
        credit[i] <= credit[i] - ONE;
      end else if (!dec[i] && s_done[i] && !ovf[i]) begin
        credit[i] <= credit[i] + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants    <= '0;
      err_credit_ovf <= 1'b0;
    end else begin
      if (hs) begin
        stat_grants <= stat_grants + 32'd1;
      end
      if (|ovf) begin
        err_credit_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    stat_credit = '0;
    for (int i = 0; i < D_COUNT; i++) begin
      stat_credit[i*CNT_WIDTH +: CNT_WIDTH] = credit[i];
    end
  end

endmodule

// File: tb/tb_ctrl_dispatch_sched.sv
// Bench for ctrl_dispatch_sched: directed cases plus random traffic
// checked every cycle against a behavioural scheduler model.
module tb_ctrl_dispatch_sched;

  localparam int D  = 4;
  localparam int CM = 2;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mode;
  logic [1:0]  ssel;
  logic [3:0]  en;
  logic        tready;
  logic [3:0]  done;
  logic [1:0]  tdata;
  logic        tvalid;
  logic [7:0]  scred;
  logic [31:0] sgr;
  logic        err;

  logic        b_mode;
  logic [1:0]  b_sel;
  logic [2:0]  b_en;
  logic        b_ready;
  logic [2:0]  b_done;
  logic [1:0]  b_tdata;
  logic        b_tvalid;
  logic [2:0]  b_cred;
  logic [31:0] b_gr;
  logic        b_err;

  always #5 clk = ~clk;

  ctrl_dispatch_sched #(
    .D_COUNT    (D),
    .CREDIT_MAX (CM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode       (cfg_mode),
    .cfg_static_sel (ssel),
    .cfg_dest_en    (en),
    .m_sel_tdata    (tdata),
    .m_sel_tvalid   (tvalid),
    .m_sel_tready   (tready),
    .s_done         (done),
    .stat_credit    (scred),
    .stat_grants    (sgr),
    .err_credit_ovf (err)
  );

  ctrl_dispatch_sched #(
    .D_COUNT    (3),
    .CREDIT_MAX (1)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode       (b_mode),
    .cfg_static_sel (b_sel),
    .cfg_dest_en    (b_en),
    .m_sel_tdata    (b_tdata),
    .m_sel_tvalid   (b_tvalid),
    .m_sel_tready   (b_ready),
    .s_done         (b_done),
    .stat_credit    (b_cred),
    .stat_grants    (b_gr),
    .err_credit_ovf (b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          mcred [D];
  bit          mvalid;
  int          mdata;
  int          mptr;
  logic [31:0] mgr;
  bit          merr;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int cand;
    bit hs;
    bit ld;
    if (rst) begin
      mvalid = 0;
      mdata  = 0;
      mptr   = 0;
      mgr    = '0;
      merr   = 0;
      for (int i = 0; i < D; i++) mcred[i] = CM;
      return;
    end
    hs   = mvalid && tready;
    cand = -1;
    if (cfg_mode) begin
      if (int'(ssel) < D && en[ssel] && mcred[ssel] > 0) cand = int'(ssel);
    end else begin
      for (int k = 0; k < D; k++) begin
        int j;
        j = (mptr + k) % D;
        if (cand < 0 && en[j] && mcred[j] > 0) cand = j;
      end
    end
    ld = (cand >= 0) && (!mvalid || hs);
    if (hs) mgr = mgr + 1;
    for (int i = 0; i < D; i++) begin
      int delta;
      delta = (ld && cand == i) ? -1 : 0;
      if (done[i]) begin
        if (delta != 0) delta = 0;
        else if (mcred[i] == CM) merr = 1;
        else delta = 1;
      end
      mcred[i] += delta;
    end
    if (ld) begin
      mvalid = 1;
      mdata  = cand;
      if (!cfg_mode) mptr = (cand + 1) % D;
    end else if (hs) begin
      mvalid = 0;
    end
  endtask

  task automatic compare();
    check("valid", 64'(tvalid), 64'(mvalid));
    if (mvalid) check("data", 64'(tdata), 64'(mdata));
    for (int i = 0; i < D; i++) begin
      check("credit", 64'(scred[i*CW +: CW]), 64'(mcred[i]));
    end
    check("grants", 64'(sgr), 64'(mgr));
    check("err", 64'(err), 64'(merr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst = 1; cfg_mode = 0; ssel = 0; en = 4'hF; tready = 1; done = 0;
    b_mode = 1; b_sel = 2'd3; b_en = 3'b111; b_ready = 1; b_done = 0;

    // T1: round-robin sweep until credits run dry
    tick();
    check("rst_data", 64'(tdata), 64'd0);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_valid", 64'(tvalid), 64'd1);
      check("t1_data", 64'(tdata), 64'(k % 4));
    end
    tick();
    check("t1_idle", 64'(tvalid), 64'd0);
    check("t1_cred", 64'(scred), 64'd0);

    // T2: a done pulse releases exactly one more selector
    done = 4'b0100;
    tick();
    done = 0;
    check("t2_wait", 64'(tvalid), 64'd0);
    tick();
    check("t2_valid", 64'(tvalid), 64'd1);
    check("t2_data", 64'(tdata), 64'd2);
    tick();
    check("t2_cred", 64'(scred[5:4]), 64'd0);
    check("t2_idle", 64'(tvalid), 64'd0);

    // T3: held selector survives enable changes
    rst = 1; tready = 0; en = 4'hF;
    tick();
    rst = 0;
    tick();
    check("t3_load", 64'(tdata), 64'd0);
    en = 4'b0001;
    repeat (3) begin
      tick();
      check("t3_hold", 64'(tdata), 64'd0);
    end
    tready = 1;
    tick();
    check("t3_next", 64'(tdata), 64'd0);
    tick();
    check("t3_idle", 64'(tvalid), 64'd0);
    check("t3_grants", 64'(sgr), 64'd2);

    // T4: static mode, plus out-of-range static select on the 3-dest unit
    rst = 1; cfg_mode = 1; ssel = 2'd3; en = 4'hF; tready = 1;
    tick();
    rst = 0;
    repeat (5) begin
      tick();
      check("t4b_novalid", 64'(b_tvalid), 64'd0);
    end
    check("t4_grants", 64'(sgr), 64'd2);
    check("t4b_grants", 64'(b_gr), 64'd0);
    done = 4'b1000;
    b_sel = 2'd2;
    tick();
    done = 0;
    repeat (3) tick();
    check("t4_release", 64'(sgr), 64'd3);
    check("t4b_grants2", 64'(b_gr), 64'd1);
    check("t4b_cred", 64'(b_cred), 64'b011);
    b_sel = 2'd3;

    // T5: same-cycle load and done, then overflow
    rst = 1; cfg_mode = 0; en = 4'b0010; tready = 0;
    tick();
    rst = 0;
    tick();
    tready = 1; done = 4'b0010;
    tick();
    check("t5_net", 64'(scred[3:2]), 64'd1);
    check("t5_data", 64'(tdata), 64'd1);
    tready = 0; done = 4'b0001;
    tick();
    done = 0;
    check("t5_ovf", 64'(err), 64'd1);
    repeat (2) tick();
    check("t5_sticky", 64'(err), 64'd1);

    // T6: reset while holding a selector
    rst = 1; en = 4'hF; tready = 1;
    tick();
    rst = 0;
    repeat (3) tick();
    tready = 0;
    tick();
    check("t6_full", 64'(tvalid), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_valid", 64'(tvalid), 64'd0);
    check("t6_cred", 64'(scred), 64'hAA);
    check("t6_grants", 64'(sgr), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_mode = ($urandom_range(0, 3) == 0);
        ssel     = 2'($urandom_range(0, 3));
        en       = 4'($urandom_range(0, 15));
      end
      tready = ($urandom_range(0, 3) != 0);
      done = 0;
      for (int i = 0; i < D; i++) begin
        if (mcred[i] < CM) done[i] = ($urandom_range(0, 2) == 0);
        else done[i] = ($urandom_range(0, 99) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
